// File: rtl/preif_pc_sequencer.sv
// Pre-IF fetch PC sequencer: selects the next fetch PC (flush > branch > +4), issues
// instruction-memory requests and buffers redirects that arrive while no request is accepted.
module preif_pc_sequencer #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h1c000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_allowin_i,
  input  logic            br_valid_i,
  input  logic [PC_W-1:0] br_pc_i,
  input  logic            flush_valid_i,
  input  logic [PC_W-1:0] flush_pc_i,
  input  logic            halt_i,
  output logic            inst_req_o,
  output logic [PC_W-1:0] inst_addr_o,
  input  logic            inst_addr_ok_i,
  output logic            preif_to_if_valid_o,
  output logic [PC_W-1:0] pc_o
);

  localparam logic [PC_W-1:0] PcStep  = PC_W'(4);
  localparam logic [PC_W-1:0] PcRstQ  = RESET_PC - PcStep;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalt
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] br_pc_q, br_pc_d;
  logic [PC_W-1:0] fl_pc_q, fl_pc_d;
  logic            br_pend_q, br_pend_d;
  logic            fl_pend_q, fl_pend_d;

  logic            fl_any;
  logic            br_any;
  logic            accept;
  logic [PC_W-1:0] next_pc;

  assign fl_any = flush_valid_i | fl_pend_q;
  assign br_any = br_valid_i | br_pend_q;

  // Live redirects take precedence over buffered ones of the same kind.
  always_comb begin
    next_pc = pc_q + PcStep;
    if (fl_any) begin
      next_pc = flush_valid_i ? flush_pc_i : fl_pc_q;
    end else if (br_any) begin
      next_pc = br_valid_i ? br_pc_i : br_pc_q;
    end
  end

  assign inst_req_o          = (state_q == StRun) & if_allowin_i & ~halt_i;
  assign accept              = inst_req_o & inst_addr_ok_i;
  assign preif_to_if_valid_o = accept;
  assign pc_o                = rst ? RESET_PC : next_pc;
  assign inst_addr_o         = pc_o;

  // Redirect buffering and last-accepted PC tracking.
  always_comb begin
    pc_d      = pc_q;
    br_pc_d   = br_pc_q;
    fl_pc_d   = fl_pc_q;
    br_pend_d = br_pend_q;
    fl_pend_d = fl_pend_q;
    if (accept) begin
      pc_d      = next_pc;
      br_pend_d = 1'b0;
      fl_pend_d = 1'b0;
    end else begin
      if (flush_valid_i) begin
        fl_pend_d = 1'b1;
        fl_pc_d   = flush_pc_i;
      end
      // A flush, live or pending, kills any buffered branch.
      if (fl_any) begin
        br_pend_d = 1'b0;
      end else if (br_valid_i) begin
        br_pend_d = 1'b1;
        br_pc_d   = br_pc_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (halt_i && !fl_any) begin
          state_d = StHalt;
        end
      end
      StHalt: begin
        if (flush_valid_i) begin
          state_d = StRun;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StBoot;
      pc_q      <= PcRstQ;
      br_pc_q   <= '0;
      fl_pc_q   <= '0;
      br_pend_q <= 1'b0;
      fl_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      br_pc_q   <= br_pc_d;
      fl_pc_q   <= fl_pc_d;
      br_pend_q <= br_pend_d;
      fl_pend_q <= fl_pend_d;
    end
  end

endmodule
